// File: rtl/program_counter.sv
// Program-counter register for the single-cycle RV32I core: loads PCnext or PC+ImmExt.
// Optional macro PC_ALIGN_EN forces the registered next value to be word-aligned.
module program_counter #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        Areset,
   input  logic [31:0] PCnext,
   input  logic [31:0] ImmExt,
   input  logic        PCSrc,
   input  logic        load,
   output logic [31:0] PC
);

   logic [31:0] branch_target_s;
   logic [31:0] next_s;
   logic [31:0] pc_r;

   // Carry-out dropped on purpose: PC-relative targets wrap silently mod 2^32.
   assign branch_target_s = pc_r + ImmExt;

   // Next-PC select, with optional word alignment of the selected address.
   always_comb begin
      next_s = PCnext;
      if (PCSrc) begin
         next_s = branch_target_s;
      end else begin
         next_s = PCnext;
      end
`ifdef PC_ALIGN_EN
      next_s[1:0] = 2'b00;
`else
      next_s[1:0] = next_s[1:0];
`endif
   end

   // PC register: asynchronous reset to the vector, load-enabled update otherwise.
   always_ff @(posedge clk or negedge Areset) begin
      if (!Areset) begin
         pc_r <= RESET_VECTOR;
      end else if (load) begin
         pc_r <= next_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign PC = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Randomized self-checking bench for program_counter against an arithmetic reference model.
module tb_program_counter;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk;
   logic        Areset;
   logic [31:0] PCnext;
   logic [31:0] ImmExt;
   logic        PCSrc;
   logic        load;
   logic [31:0] PC;

   int          vec_count  = 0;
   int          miscompares = 0;
   logic [31:0] pc_m;

   program_counter #(.RESET_VECTOR(RV)) dut (
      .clk    (clk),
      .Areset (Areset),
      .PCnext (PCnext),
      .ImmExt (ImmExt),
      .PCSrc  (PCSrc),
      .load   (load),
      .PC     (PC)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: PC=%h expected %h", tag, got, exp);
      end
   endtask

   // Reference: next PC from the architectural rule, word-masked when alignment is on.
   function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic src,
                                            input logic [31:0] nx, input logic [31:0] imm);
      logic [31:0] r;
      r = src ? (cur + imm) : nx;
`ifdef PC_ALIGN_EN
      r = r & 32'hFFFF_FFFC;
`endif
      return r;
   endfunction

   task automatic drive(input logic rst, input logic ld, input logic src,
                        input logic [31:0] nx, input logic [31:0] imm);
      @(negedge clk);
      Areset = rst;
      load   = ld;
      PCSrc  = src;
      PCnext = nx;
      ImmExt = imm;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!Areset) pc_m = RV;
      else if (load) pc_m = ref_next(pc_m, PCSrc, PCnext, ImmExt);
      #1;
      check(tag, PC, pc_m);
   endtask

   initial begin
      Areset = 1'b1;
      load   = 1'b0;
      PCSrc  = 1'b0;
      PCnext = 32'h0;
      ImmExt = 32'h0;
      pc_m   = RV;

      // Asynchronous reset in mid-cycle, visible before any clock edge.
      #5 Areset = 1'b0;
      #1 check("reset_async", PC, RV);
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
      step("reset_hold");
      step("reset_hold2");

      drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      step("seq_load");
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0004);
      step("branch_1");
      step("branch_2");

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'($urandom), $urandom, $urandom);
         #2 PCnext = $urandom;
         ImmExt = $urandom;
         step("hold");
      end

      drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
      step("load_14");
      drive(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFF0);
      step("neg_offset");
      drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
      step("load_top");
      drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0008);
      step("wrap");

      // Reset across a pending load discards that load.
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0023, 32'h0);
      #1 check("rst_async_load", PC, RV);
      step("rst_during_load");
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0023, 32'h0);
      step("post_rst_load");

      for (int i = 0; i < 300; i++) begin
         logic [31:0] imm;
         imm = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 64)) - 32'd32) : $urandom;
         drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               $urandom, imm);
         if (!Areset) begin
            #1;
            pc_m = RV;
            check("rand_async_rst", PC, pc_m);
         end
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
